// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
//   opcode_t    : memory opcodes (MIPS primary-opcode encoding) plus a
//                 non-memory OP_NOP code used as the idle/reset value.
//   lsu_state_t : IDLE / ACCESS / DONE transaction state.
//   is_load / is_store / is_mem : opcode class helpers.
package lsu_pkg;

    typedef enum logic [5:0] {
        OP_NOP = 6'h00,
        OP_LB  = 6'h20,
        OP_LH  = 6'h21,
        OP_LW  = 6'h23,
        OP_LBU = 6'h24,
        OP_LHU = 6'h25,
        OP_SB  = 6'h28,
        OP_SH  = 6'h29,
        OP_SW  = 6'h2B
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    function automatic logic is_load(input opcode_t op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input opcode_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_mem(input opcode_t op);
        return is_load(op) || is_store(op);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational byte-lane logic for the load/store unit.
//   opcode_i     : access opcode
//   offset_i     : byte offset within the word (ea[1:0])
//   rt_i         : right-justified store data
//   readdata_i   : raw word returned by the bus
//   byteenable_o : active byte lanes for the access
//   writedata_o  : store data replicated across the lanes
//   load_data_o  : extracted, sign/zero-extended load result
//   misaligned_o : half on odd address or word on non-zero offset
module lsu_align
    import lsu_pkg::*;
(
    input  opcode_t     opcode_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] readdata_i,
    output logic [3:0]  byteenable_o,
    output logic [31:0] writedata_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o
);

    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = readdata_i[8*gi +: 8];
    end

    // Half selection only looks at offset[1]; odd offsets never reach the
    // bus because they are rejected as misaligned.
    assign sel_byte = lane[offset_i];
    assign sel_half = {lane[{offset_i[1], 1'b1}], lane[{offset_i[1], 1'b0}]};

    always_comb begin
        byteenable_o = 4'b0000;
        writedata_o  = 32'h0;
        load_data_o  = 32'h0;
        misaligned_o = 1'b0;
        case (opcode_i)
            OP_LB, OP_LBU, OP_SB: begin
                byteenable_o = 4'b0001 << offset_i;
                writedata_o  = {4{rt_i[7:0]}};
                load_data_o  = (opcode_i == OP_LB) ? {{24{sel_byte[7]}}, sel_byte}
                                                   : {24'h0, sel_byte};
            end
            OP_LH, OP_LHU, OP_SH: begin
                byteenable_o = 4'b0011 << {offset_i[1], 1'b0};
                writedata_o  = {2{rt_i[15:0]}};
                load_data_o  = (opcode_i == OP_LH) ? {{16{sel_half[15]}}, sel_half}
                                                   : {16'h0, sel_half};
                misaligned_o = offset_i[0];
            end
            OP_LW, OP_SW: begin
                byteenable_o = 4'b1111;
                writedata_o  = rt_i;
                load_data_o  = readdata_i;
                misaligned_o = |offset_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs one Avalon-style data-memory transaction per
// accepted request and stalls the pipeline until it completes.
//   clk, reset_n          : clock, synchronous active-low reset
//   req_i, opcode_i       : request valid and memory opcode
//   effective_address_i   : byte address, rt_i : right-justified store data
//   load_data_o, done_o   : extended load result and completion pulse
//   addr_error_o          : misaligned request rejected (one cycle)
//   stall_o               : pipeline hold
//   address_o, read_o, write_o, byteenable_o, writedata_o : bus command
//   waitrequest_i, readdata_i : bus response
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_i,
    input  opcode_t     opcode_i,
    input  logic [31:0] effective_address_i,
    input  logic [31:0] rt_i,
    output logic [31:0] load_data_o,
    output logic        done_o,
    output logic        addr_error_o,
    output logic        stall_o,
    output logic [31:0] address_o,
    output logic        read_o,
    output logic        write_o,
    output logic [3:0]  byteenable_o,
    output logic [31:0] writedata_o,
    input  logic        waitrequest_i,
    input  logic [31:0] readdata_i
);

    lsu_state_t  state_q, state_d;
    opcode_t     op_q, op_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] writedata_q, writedata_d;
    logic [31:0] load_data_q, load_data_d;

    opcode_t     align_op;
    logic [1:0]  align_offset;
    logic [3:0]  align_be;
    logic [31:0] align_wd;
    logic [31:0] align_ld;
    logic        align_misaligned;
    logic        mem_req;
    logic        accept;

    // The single lane unit is shared: in IDLE it decodes the incoming
    // request (enables, store data, alignment); in ACCESS it extracts the
    // load result from the latched opcode and offset.
    assign align_op     = (state_q == ACCESS) ? op_q     : opcode_i;
    assign align_offset = (state_q == ACCESS) ? offset_q : effective_address_i[1:0];

    lsu_align u_align (
        .opcode_i     (align_op),
        .offset_i     (align_offset),
        .rt_i         (rt_i),
        .readdata_i   (readdata_i),
        .byteenable_o (align_be),
        .writedata_o  (align_wd),
        .load_data_o  (align_ld),
        .misaligned_o (align_misaligned)
    );

    assign mem_req = req_i && is_mem(opcode_i);
    assign accept  = (state_q == IDLE) && mem_req && !align_misaligned;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)         state_d = ACCESS;
            ACCESS:  if (!waitrequest_i) state_d = DONE;
            DONE:                        state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        done_o       = (state_q == DONE);
        stall_o      = accept || (state_q == ACCESS);
        addr_error_o = (state_q == IDLE) && mem_req && align_misaligned;
    end

    // Bus command and load result registers
    always_comb begin
        op_d         = op_q;
        offset_d     = offset_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        byteenable_d = byteenable_q;
        writedata_d  = writedata_q;
        load_data_d  = load_data_q;
        if (accept) begin
            op_d         = opcode_i;
            offset_d     = effective_address_i[1:0];
            address_d    = {effective_address_i[31:2], 2'b00};
            read_d       = is_load(opcode_i);
            write_d      = is_store(opcode_i);
            byteenable_d = align_be;
            writedata_d  = align_wd;
        end else if ((state_q == ACCESS) && !waitrequest_i) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            if (is_load(op_q)) begin
                load_data_d = align_ld;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q         <= OP_NOP;
            offset_q     <= 2'b00;
            address_q    <= 32'h0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            byteenable_q <= 4'b0000;
            writedata_q  <= 32'h0;
            load_data_q  <= 32'h0;
        end else begin
            op_q         <= op_d;
            offset_q     <= offset_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            byteenable_q <= byteenable_d;
            writedata_q  <= writedata_d;
            load_data_q  <= load_data_d;
        end
    end

    assign address_o    = address_q;
    assign read_o       = read_q;
    assign write_o      = write_q;
    assign byteenable_o = byteenable_q;
    assign writedata_o  = writedata_q;
    assign load_data_o  = load_data_q;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: hand-computed vectors, one line per
// transaction, all comparisons through the check task.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req_i;
    opcode_t     opcode_i;
    logic [31:0] effective_address_i;
    logic [31:0] rt_i;
    logic [31:0] load_data_o;
    logic        done_o;
    logic        addr_error_o;
    logic        stall_o;
    logic [31:0] address_o;
    logic        read_o;
    logic        write_o;
    logic [3:0]  byteenable_o;
    logic [31:0] writedata_o;
    logic        waitrequest_i;
    logic [31:0] readdata_i;

    int n_checks;
    int n_errors;

    lsu dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .req_i               (req_i),
        .opcode_i            (opcode_i),
        .effective_address_i (effective_address_i),
        .rt_i                (rt_i),
        .load_data_o         (load_data_o),
        .done_o              (done_o),
        .addr_error_o        (addr_error_o),
        .stall_o             (stall_o),
        .address_o           (address_o),
        .read_o              (read_o),
        .write_o             (write_o),
        .byteenable_o        (byteenable_o),
        .writedata_o         (writedata_o),
        .waitrequest_i       (waitrequest_i),
        .readdata_i          (readdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction. readdata carries a decoy value while
    // waitrequest is high so an early sample would show up in load_data_o.
    task automatic access(input string tag, input opcode_t op,
                          input logic [31:0] ea, input logic [31:0] rt,
                          input logic [31:0] rd, input int waits,
                          input logic exp_rd, input logic exp_wr,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_ld);
        int n;
        req_i               = 1'b1;
        opcode_i            = op;
        effective_address_i = ea;
        rt_i                = rt;
        waitrequest_i       = 1'b0;
        readdata_i          = 32'h5A5A_5A5A;
        #1;
        check({tag, "_stall_req"}, {31'b0, stall_o}, 32'd1);
        check({tag, "_no_err"}, {31'b0, addr_error_o}, 32'd0);
        step();
        check({tag, "_addr"}, address_o, exp_addr);
        check({tag, "_be"}, {28'b0, byteenable_o}, {28'b0, exp_be});
        if (exp_wr) check({tag, "_wd"}, writedata_o, exp_wd);
        n = 0;
        while (!done_o && n < 20) begin
            waitrequest_i = (n < waits);
            readdata_i    = (n < waits) ? 32'h5A5A_5A5A : rd;
            check({tag, "_stall_acc"}, {31'b0, stall_o}, 32'd1);
            check({tag, "_read"}, {31'b0, read_o}, {31'b0, exp_rd});
            check({tag, "_write"}, {31'b0, write_o}, {31'b0, exp_wr});
            step();
            n++;
        end
        waitrequest_i = 1'b0;
        check({tag, "_latency"}, n, waits + 1);
        check({tag, "_done"}, {31'b0, done_o}, 32'd1);
        check({tag, "_strobes_off"}, {30'b0, read_o, write_o}, 32'd0);
        check({tag, "_stall_done"}, {31'b0, stall_o}, 32'd0);
        if (exp_rd) check({tag, "_load"}, load_data_o, exp_ld);
        $display("txn %s op=%s ea=0x%08h be=%b wd=0x%08h ld=0x%08h cycles=%0d",
                 tag, op.name(), ea, byteenable_o, writedata_o, load_data_o, n);
        req_i = 1'b0;
        step();
        check({tag, "_done_pulse"}, {31'b0, done_o}, 32'd0);
    endtask

    initial begin
        n_checks            = 0;
        n_errors            = 0;
        reset_n             = 1'b0;
        req_i               = 1'b0;
        opcode_i            = OP_NOP;
        effective_address_i = 32'h0;
        rt_i                = 32'h0;
        waitrequest_i       = 1'b0;
        readdata_i          = 32'h0;
        step();
        step();
        reset_n = 1'b1;
        step();
        check("rst_read", {31'b0, read_o}, 32'd0);
        check("rst_write", {31'b0, write_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_err", {31'b0, addr_error_o}, 32'd0);
        check("rst_stall", {31'b0, stall_o}, 32'd0);
        check("rst_be", {28'b0, byteenable_o}, 32'd0);
        check("rst_addr", address_o, 32'd0);
        check("rst_wd", writedata_o, 32'd0);
        check("rst_ld", load_data_o, 32'd0);
        $display("txn reset: outputs idle");

        //      tag     op      ea            rt            readdata      w  rd    wr    addr          be       wd            load
        access("sw",   OP_SW,  32'h0000_1000, 32'hDEAD_BEEF, 32'h0,        0, 1'b0, 1'b1, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        access("lb",   OP_LB,  32'h0000_2003, 32'h0,         32'h8000_0000, 3, 1'b1, 1'b0, 32'h0000_2000, 4'b1000, 32'h0,         32'hFFFF_FF80);
        access("lbu",  OP_LBU, 32'h0000_2003, 32'h0,         32'h8000_0000, 0, 1'b1, 1'b0, 32'h0000_2000, 4'b1000, 32'h0,         32'h0000_0080);
        access("sh",   OP_SH,  32'h0000_3002, 32'h0000_4142, 32'h0,         1, 1'b0, 1'b1, 32'h0000_3000, 4'b1100, 32'h4142_4142, 32'h0);
        access("lh",   OP_LH,  32'h0000_3002, 32'h0,         32'h8001_FFFF, 0, 1'b1, 1'b0, 32'h0000_3000, 4'b1100, 32'h0,         32'hFFFF_8001);
        access("lhu",  OP_LHU, 32'h0000_3000, 32'h0,         32'h8001_FFFF, 2, 1'b1, 1'b0, 32'h0000_3000, 4'b0011, 32'h0,         32'h0000_FFFF);
        access("lb1",  OP_LB,  32'h0000_2001, 32'h0,         32'h0000_7F00, 0, 1'b1, 1'b0, 32'h0000_2000, 4'b0010, 32'h0,         32'h0000_007F);
        access("lw",   OP_LW,  32'h0000_8004, 32'h0,         32'h1234_5678, 1, 1'b1, 1'b0, 32'h0000_8004, 4'b1111, 32'h0,         32'h1234_5678);

        // Misaligned word: error pulse, no stall, no bus activity
        req_i               = 1'b1;
        opcode_i            = OP_LW;
        effective_address_i = 32'h0000_4001;
        #1;
        check("mis_err", {31'b0, addr_error_o}, 32'd1);
        check("mis_stall", {31'b0, stall_o}, 32'd0);
        step();
        req_i = 1'b0;
        #1;
        check("mis_err_drop", {31'b0, addr_error_o}, 32'd0);
        check("mis_read", {31'b0, read_o}, 32'd0);
        step();
        check("mis_done", {31'b0, done_o}, 32'd0);
        check("mis_read2", {31'b0, read_o}, 32'd0);
        $display("txn misaligned LW ea=0x00004001 rejected");

        // Misaligned half
        req_i               = 1'b1;
        opcode_i            = OP_SH;
        effective_address_i = 32'h0000_3003;
        #1;
        check("mish_err", {31'b0, addr_error_o}, 32'd1);
        check("mish_stall", {31'b0, stall_o}, 32'd0);
        req_i = 1'b0;
        step();
        check("mish_write", {31'b0, write_o}, 32'd0);
        $display("txn misaligned SH ea=0x00003003 rejected");

        // Non-memory opcode is ignored
        req_i               = 1'b1;
        opcode_i            = OP_NOP;
        effective_address_i = 32'h0000_4001;
        #1;
        check("nop_stall", {31'b0, stall_o}, 32'd0);
        check("nop_err", {31'b0, addr_error_o}, 32'd0);
        step();
        check("nop_strobes", {30'b0, read_o, write_o}, 32'd0);
        req_i = 1'b0;
        $display("txn non-memory opcode ignored");

        // Reset during a waiting read abandons the transaction
        req_i               = 1'b1;
        opcode_i            = OP_LW;
        effective_address_i = 32'h0000_7000;
        waitrequest_i       = 1'b1;
        step();
        check("rsta_read", {31'b0, read_o}, 32'd1);
        reset_n = 1'b0;
        req_i   = 1'b0;
        step();
        check("rsta_read_drop", {31'b0, read_o}, 32'd0);
        check("rsta_done", {31'b0, done_o}, 32'd0);
        check("rsta_addr", address_o, 32'd0);
        reset_n       = 1'b1;
        waitrequest_i = 1'b0;
        step();
        check("rsta_idle_done", {31'b0, done_o}, 32'd0);
        check("rsta_idle_stall", {31'b0, stall_o}, 32'd0);
        check("rsta_idle_read", {31'b0, read_o}, 32'd0);
        $display("txn reset during ACCESS: abandoned");

        // Back-to-back SB then LW with req held: one bubble after done
        req_i               = 1'b1;
        opcode_i            = OP_SB;
        effective_address_i = 32'h0000_5001;
        rt_i                = 32'h0000_00AB;
        step();
        check("b2b_sb_write", {31'b0, write_o}, 32'd1);
        check("b2b_sb_be", {28'b0, byteenable_o}, 32'h2);
        check("b2b_sb_wd", writedata_o, 32'hABAB_ABAB);
        step();
        check("b2b_sb_done", {31'b0, done_o}, 32'd1);
        opcode_i            = OP_LW;
        effective_address_i = 32'h0000_6000;
        readdata_i          = 32'h1234_5678;
        #1;
        check("b2b_done_stall", {31'b0, stall_o}, 32'd0);
        check("b2b_done_read", {31'b0, read_o}, 32'd0);
        step();
        check("b2b_bubble_read", {31'b0, read_o}, 32'd0);
        check("b2b_bubble_done", {31'b0, done_o}, 32'd0);
        check("b2b_bubble_stall", {31'b0, stall_o}, 32'd1);
        step();
        check("b2b_lw_read", {31'b0, read_o}, 32'd1);
        check("b2b_lw_addr", address_o, 32'h0000_6000);
        step();
        check("b2b_lw_done", {31'b0, done_o}, 32'd1);
        check("b2b_lw_load", load_data_o, 32'h1234_5678);
        req_i = 1'b0;
        step();
        $display("txn back-to-back SB/LW: strobe one cycle after done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
